// File: rtl/crypto_wallet2_seed_pkg.sv
// ============================================================================
// Module      : crypto_wallet2_seed_pkg
// Description : Shared state encoding, LFSR taps and step function for the
//               seed scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crypto_wallet2_seed_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READY = 2'd1,
    GRANT = 2'd2,
    STALE = 2'd3
  } seed_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One Galois step, shifting right with feedback from bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crypto_wallet2_rr_arbiter.sv
// ============================================================================
// Module      : crypto_wallet2_rr_arbiter
// Description : Combinational round-robin pick: first set request bit at or
//               above rr_ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_wallet2_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any_req,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int PTR_W = $clog2(NUM_REQ);

  int w_idx;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    w_idx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[w_idx]) begin
        any_req = 1'b1;
        winner  = PTR_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crypto_wallet2_seed_sched.sv
// ============================================================================
// Module      : crypto_wallet2_seed_sched
// Description : Expands each firmware seed into MAX_USES LFSR words and hands
//               them out one per grant, round-robin among requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_wallet2_seed_sched #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_USES = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [31:0]                     seed_in,
  input  logic [NUM_REQ-1:0]              req,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [31:0]                     seed_out,
  output logic                            seed_valid,
  output logic [$clog2(MAX_USES+1)-1:0]   uses_left,
  output logic                            stale
);

  import crypto_wallet2_seed_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int UW    = $clog2(MAX_USES + 1);
  localparam logic [NUM_REQ-1:0] C_ONE_HOT0 = NUM_REQ'(1);

  seed_state_e       r_state;
  seed_state_e       w_state_next;
  logic [31:0]       r_lfsr;
  logic [31:0]       r_last_seed;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [UW-1:0]     r_uses_left;
  logic [NUM_REQ-1:0] r_gnt;
  logic [31:0]       r_seed_out;
  logic              r_seed_valid;
  logic              r_stale;

  logic              w_new_seed;
  logic              w_any_req;
  logic [PTR_W-1:0]  w_winner;
  logic              w_do_grant;
  logic [31:0]       w_lfsr_step;
  logic [PTR_W-1:0]  w_ptr_next;

  crypto_wallet2_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .any_req (w_any_req),
    .winner  (w_winner)
  );

  // Zero would lock the LFSR, so it never counts as a fresh seed.
  assign w_new_seed  = (seed_in != r_last_seed) && (seed_in != 32'h0);
  assign w_do_grant  = (r_state == READY) && !w_new_seed && w_any_req;
  assign w_lfsr_step = lfsr_next(r_lfsr);
  assign w_ptr_next  = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_new_seed) w_state_next = READY;
      READY:   if (w_new_seed) w_state_next = READY;
               else if (w_any_req) w_state_next = GRANT;
      GRANT:   if (w_new_seed) w_state_next = READY;
               else if (r_uses_left == '0) w_state_next = STALE;
               else w_state_next = READY;
      STALE:   if (w_new_seed) w_state_next = READY;
      default: w_state_next = EMPTY;
    endcase
  end

  // Grant outputs are launched on the READY->GRANT edge so they are pure flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr       <= '0;
      r_last_seed  <= '0;
      r_rr_ptr     <= '0;
      r_uses_left  <= '0;
      r_gnt        <= '0;
      r_seed_out   <= '0;
      r_seed_valid <= 1'b0;
      r_stale      <= 1'b0;
    end else begin
      r_gnt        <= '0;
      r_seed_valid <= 1'b0;
      r_stale      <= (w_state_next == STALE);
      if (w_do_grant) begin
        r_gnt        <= C_ONE_HOT0 << w_winner;
        r_seed_valid <= 1'b1;
        r_seed_out   <= w_lfsr_step;
        r_lfsr       <= w_lfsr_step;
        r_uses_left  <= r_uses_left - UW'(1);
        r_rr_ptr     <= w_ptr_next;
      end else if (w_new_seed) begin
        r_lfsr      <= seed_in;
        r_last_seed <= seed_in;
        r_uses_left <= UW'(MAX_USES);
      end
    end
  end

  assign gnt        = r_gnt;
  assign seed_out   = r_seed_out;
  assign seed_valid = r_seed_valid;
  assign uses_left  = r_uses_left;
  assign stale      = r_stale;

endmodule

`default_nettype wire

// File: tb/tb_crypto_wallet2_seed_sched.sv
// ============================================================================
// Module      : tb_crypto_wallet2_seed_sched
// Description : Directed self-checking bench for the seed scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crypto_wallet2_seed_sched;

  logic        clk;
  logic        reset_n;
  logic [31:0] seed_in;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] seed_out;
  logic        seed_valid;
  logic [3:0]  uses_left;
  logic        stale;

  int checks = 0;
  int errors = 0;

  logic [31:0] rr_exp [8] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                              32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003};

  crypto_wallet2_seed_sched #(
    .NUM_REQ  (4),
    .MAX_USES (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seed_in    (seed_in),
    .req        (req),
    .gnt        (gnt),
    .seed_out   (seed_out),
    .seed_valid (seed_valid),
    .uses_left  (uses_left),
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt),        32'h0);
    check({tag, "_sout"},  seed_out,        32'h0);
    check({tag, "_valid"}, 32'(seed_valid), 32'h0);
    check({tag, "_uses"},  32'(uses_left),  32'h0);
    check({tag, "_stale"}, 32'(stale),      32'h0);
  endtask

  initial begin
    // Reset with live inputs, then a zero seed never starts anything.
    reset_n = 1'b0; req = 4'hF; seed_in = 32'd5;
    step(); step(); step();
    check_all_zero("rst");
    seed_in = 32'h0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("zero_seed_gnt", 32'(gnt), 32'h0);
    end

    // First seed.
    seed_in = 32'd1; req = 4'b0001;
    step();
    check("s1_load_gnt", 32'(gnt), 32'h0);
    check("s1_load_uses", 32'(uses_left), 32'd8);
    step();
    check("s1_g1_gnt", 32'(gnt), 32'h1);
    check("s1_g1_valid", 32'(seed_valid), 32'h1);
    check("s1_g1_sout", seed_out, 32'h8020_0003);
    check("s1_g1_uses", 32'(uses_left), 32'd7);
    step();
    check("s1_gap_gnt", 32'(gnt), 32'h0);
    check("s1_gap_valid", 32'(seed_valid), 32'h0);
    check("s1_hold_sout", seed_out, 32'h8020_0003);
    step();
    check("s1_g2_gnt", 32'(gnt), 32'h1);
    check("s1_g2_sout", seed_out, 32'hC030_0002);
    check("s1_g2_uses", 32'(uses_left), 32'd6);

    // Round-robin then exhaustion, starting from a clean pointer.
    reset_n = 1'b0; req = 4'hF; seed_in = 32'd2;
    step();
    reset_n = 1'b1;
    step();
    check("rr_load_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      check("rr_sout", seed_out, rr_exp[k]);
      check("rr_uses", 32'(uses_left), 32'(7 - k));
      if (k < 7) begin
        step();
        check("rr_gap_gnt", 32'(gnt), 32'h0);
      end
    end
    check("ex_last_stale", 32'(stale), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ex_stale", 32'(stale), 32'h1);
      check("ex_uses", 32'(uses_left), 32'h0);
      check("ex_gnt", 32'(gnt), 32'h0);
    end
    seed_in = 32'd3;
    step();
    check("ex_clr_stale", 32'(stale), 32'h0);
    check("ex_clr_uses", 32'(uses_left), 32'd8);
    step();
    check("ex_resume_gnt", 32'(gnt), 32'h1);
    check("ex_resume_sout", seed_out, 32'h8020_0002);

    // New seed arriving in the GRANT cycle.
    req = 4'b0000;
    step();
    seed_in = 32'd1; req = 4'b0001;
    step();
    check("col_load_uses", 32'(uses_left), 32'd8);
    step();
    check("col_g_gnt", 32'(gnt), 32'h1);
    check("col_g_sout", seed_out, 32'h8020_0003);
    seed_in = 32'd7;
    step();
    check("col_reload_uses", 32'(uses_left), 32'd8);
    check("col_reload_gnt", 32'(gnt), 32'h0);
    check("col_hold_sout", seed_out, 32'h8020_0003);
    step();
    check("col_new_gnt", 32'(gnt), 32'h1);
    check("col_new_sout", seed_out, 32'h8020_0000);
    check("col_new_uses", 32'(uses_left), 32'd7);

    // Reset dropped mid-grant clears outputs without waiting for a clock.
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    seed_in = 32'h0; req = 4'hF;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_mid_empty_gnt", 32'(gnt), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
